// File: rtl/morse_pkg.sv
// Shared Morse types, letter codes, timing thresholds and the A..H decode table.
// Debounce is enabled in morse_key_conditioner via MORSE_RX_DEBOUNCE_EN.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE
  } state_t;

  typedef enum logic [2:0] {
    LTR_A,
    LTR_B,
    LTR_C,
    LTR_D,
    LTR_E,
    LTR_F,
    LTR_G,
    LTR_H
  } letter_t;

  localparam int DOT_DASH_HALF   = 3;
  localparam int LETTER_GAP_HALF = 4;
  localparam int MAX_SYMBOLS     = 4;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } code_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] letter;
  } decode_t;

  // Indexed by letter code; patterns are right-aligned, newest symbol in bit 0.
  localparam code_t CODE_TABLE [8] = '{
    '{len: 3'd2, pat: 4'b0001},
    '{len: 3'd4, pat: 4'b1000},
    '{len: 3'd4, pat: 4'b1010},
    '{len: 3'd3, pat: 4'b0100},
    '{len: 3'd1, pat: 4'b0000},
    '{len: 3'd4, pat: 4'b0010},
    '{len: 3'd3, pat: 4'b0110},
    '{len: 3'd4, pat: 4'b0000}
  };

  function automatic decode_t decode(
    input logic [2:0] len,
    input logic [3:0] pat
  );
    decode_t d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if (!d.hit && len == CODE_TABLE[i].len
          && pat == CODE_TABLE[i].pat) begin
        d.hit    = 1'b1;
        d.letter = 3'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/morse_key_conditioner.sv
// Two-flop synchronizer for the keyed line plus optional debounce.
// Debounce is built only when MORSE_RX_DEBOUNCE_EN is defined.
module morse_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_f
);

  logic s1;
  logic key_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      key_s <= 1'b0;
    end else begin
      s1    <= key_in;
      key_s <= s1;
    end
  end

`ifdef MORSE_RX_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // key_f follows key_s only after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      key_f <= 1'b0;
    end else if (key_s == key_f) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      key_f <= key_s;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign key_f = key_s;

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
  end
`endif

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: times marks/spaces in half units and decodes letters A..H.
// Define MORSE_RX_DEBOUNCE_EN to add input debounce.
module morse_rx_decoder #(
  parameter int unsigned UNIT_CYCLES     = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [3:0] pattern,
  output logic [2:0] sym_count
);

  import morse_pkg::*;

  localparam int unsigned HALF = UNIT_CYCLES / 2;
  localparam int PW = $clog2(HALF);

  logic          key_f;
  logic          key_d;
  logic          rise;
  logic          fall;
  logic          edge_f;
  logic          half_tick;
  logic [PW-1:0] pre;
  logic [3:0]    half_units;
  state_t        state;
  state_t        nxt;
  logic          capture;
  logic          sym;
  logic          gap;
  logic          ovf;
  decode_t       dec;

  morse_key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .key_in (key_in),
    .key_f  (key_f)
  );

  assign rise      = key_f & ~key_d;
  assign fall      = ~key_f & key_d;
  assign edge_f    = rise | fall;
  assign half_tick = (pre == PW'(HALF - 1));

  // The edge cycle itself counts as prescaler step 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_d      <= 1'b0;
      pre        <= '0;
      half_units <= '0;
    end else begin
      key_d <= key_f;
      if (edge_f) begin
        pre        <= PW'(1);
        half_units <= '0;
      end else if (half_tick) begin
        pre <= '0;
        if (half_units != 4'hf) begin
          half_units <= half_units + 4'd1;
        end
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (rise) nxt = ST_MARK;
      ST_MARK:  if (fall) nxt = ST_SPACE;
      ST_SPACE: begin
        if (gap) begin
          nxt = rise ? ST_MARK : ST_IDLE;
        end else if (rise) begin
          nxt = ST_MARK;
        end
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = (state == ST_MARK) && fall && (half_units != 4'd0);
    sym     = (half_units >= 4'(DOT_DASH_HALF));
    gap     = (state == ST_SPACE) && half_tick
              && (half_units == 4'(LETTER_GAP_HALF - 1));
  end

  assign dec = decode(sym_count, pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      letter       <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      pattern      <= '0;
      sym_count    <= '0;
      ovf          <= 1'b0;
    end else if (gap) begin
      letter_valid <= dec.hit & ~ovf;
      letter_err   <= ~(dec.hit & ~ovf);
      if (dec.hit && !ovf) begin
        letter <= dec.letter;
      end
      pattern   <= '0;
      sym_count <= '0;
      ovf       <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      if (capture) begin
        if (sym_count == 3'(MAX_SYMBOLS)) begin
          ovf <= 1'b1;
        end else begin
          pattern   <= {pattern[2:0], sym};
          sym_count <= sym_count + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder with UNIT_CYCLES = 10.
// The bounce scenario runs only when MORSE_RX_DEBOUNCE_EN is defined.
module tb_morse_rx_decoder;

  localparam int UNIT = 10;
  localparam int DB   = 3;
`ifdef MORSE_RX_DEBOUNCE_EN
  localparam int LAT  = 2 + 2 * UNIT + DB;
  localparam int SETL = 8;
`else
  localparam int LAT  = 2 + 2 * UNIT;
  localparam int SETL = 5;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_in = 1'b0;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic [3:0] pattern;
  logic [2:0] sym_count;

  morse_rx_decoder #(
    .UNIT_CYCLES    (UNIT),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_in      (key_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .pattern     (pattern),
    .sym_count   (sym_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         err;
    logic [2:0] letter;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_rel = 0;
  logic [2:0] held = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int len);
    key_in = 1'b1;
    idle(len);
    key_in = 1'b0;
    last_rel = cyc;
  endtask

  task automatic expect_pulse(input bit err, input logic [2:0] l);
    exp_t e;
    if (!err) held = l;
    e.err    = err;
    e.letter = held;
    e.cyc    = last_rel + LAT;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (letter_valid || letter_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_both", int'(letter_valid & letter_err), 0);
        chk("pulse_is_err", int'(letter_err), int'(e.err));
        chk("pulse_letter", int'(letter), int'(e.letter));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // reset and idle
    idle(3);
    reset_n = 1'b1;
    chk("rst_letter", int'(letter), 0);
    chk("rst_valid", int'(letter_valid), 0);
    chk("rst_err", int'(letter_err), 0);
    chk("rst_pattern", int'(pattern), 0);
    chk("rst_sym_count", int'(sym_count), 0);
    idle(100);

    // A: dot, dash
    mark(10); idle(10);
    mark(20);
    expect_pulse(1'b0, 3'd0);
    idle(SETL);
    chk("a_pattern", int'(pattern), 4'b0001);
    chk("a_sym_count", int'(sym_count), 2);
    idle(40);

    // H then G
    for (int i = 0; i < 3; i++) begin
      mark(10); idle(10);
    end
    mark(10);
    expect_pulse(1'b0, 3'd7);
    idle(40);
    mark(20); idle(10);
    mark(20); idle(10);
    mark(10);
    expect_pulse(1'b0, 3'd6);
    idle(SETL);
    chk("g_pattern", int'(pattern), 4'b0110);
    idle(40);

    // five dots overflow
    for (int i = 0; i < 4; i++) begin
      mark(10); idle(10);
    end
    mark(10);
    expect_pulse(1'b1, 3'd0);
    idle(SETL);
    chk("ovf_sym_count", int'(sym_count), 4);
    chk("ovf_pattern", int'(pattern), 0);
    idle(40);
    chk("ovf_letter_held", int'(letter), 6);

    // glitch then E
    mark(3); idle(10);
    chk("glitch_sym_count", int'(sym_count), 0);
    mark(10);
    expect_pulse(1'b0, 3'd4);
    idle(40);

    // reset after two symbols of B
    mark(20); idle(10);
    mark(10); idle(SETL);
    chk("b2_sym_count", int'(sym_count), 2);
    chk("b2_pattern", int'(pattern), 4'b0010);
    reset_n = 1'b0;
    held = 3'd0;
    @(negedge clk);
    chk("midrst_sym_count", int'(sym_count), 0);
    chk("midrst_pattern", int'(pattern), 0);
    chk("midrst_letter", int'(letter), 0);
    reset_n = 1'b1;
    idle(60);

`ifdef MORSE_RX_DEBOUNCE_EN
    // bounced E
    key_in = 1'b1; idle(1);
    key_in = 1'b0; idle(1);
    key_in = 1'b1; idle(10);
    key_in = 1'b0; idle(1);
    key_in = 1'b1; idle(1);
    key_in = 1'b0;
    last_rel = cyc;
    expect_pulse(1'b0, 3'd4);
    idle(SETL);
    chk("bounce_sym_count", int'(sym_count), 1);
    chk("bounce_pattern", int'(pattern), 0);
    idle(40);
`endif

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_rx_decoder.md
# morse_rx_decoder

Receiving end of the lab's Morse link. It samples a single keyed line (a push-button or the blinking output of the Morse transmitter looped back), times marks and spaces in half-unit steps, and classifies each mark as a dot or a dash. When it detects a letter gap, it decodes the accumulated pattern to one of letters A–H and emits a one-cycle result pulse. It sits between the board inputs and the LEDR/HEX display logic of the lab top level.

## Interface
- UNIT_CYCLES, 25000000: clk cycles per Morse unit (0.5 s at 50 MHz). Must be even and ≥ 4.
- DEBOUNCE_CYCLES, 500000: stable-input cycles required; used only with the debounce macro.
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous, active-low reset; one clock; all state clears immediately.
- key_in  in  1  keyed line, 1 = mark; asynchronous to clk.
- letter  out  3  decoded letter, 0..7 = A..H; held until the next valid letter.
- letter_valid  out  1  one-cycle pulse; letter updated this cycle.
- letter_err  out  1  one-cycle pulse; pattern was unrecognized, empty or overflowed.
- pattern  out  4  symbols of the current letter, newest in bit 0; 1 = dash.
- sym_count  out  3  symbols captured so far (0..4).

## Operation
- Input conditioning: 2-flop synchronizer to key_s, then optional debounce to key_f. All timing uses key_f.
- Half-unit prescaler: counts 0..UNIT_CYCLES/2−1 and produces half_tick at the terminal count. It clears on every key_f edge.
- half_units: 4-bit counter incremented on half_tick, saturating at 15, cleared on every key_f edge.
- FSM states are IDLE, MARK and SPACE.
  - IDLE: key_f rises → MARK.
  - MARK: key_f falls → SPACE, and the mark is classified:
    - half_units = 0: glitch, discarded; pattern and sym_count unchanged.
    - half_units 1–2: dot (0).
    - half_units ≥ 3: dash (1).
  - Symbol capture: pattern ← {pattern[2:0], sym}; sym_count++.
  - Fifth symbol: sets an internal overflow flag. Pattern and count are not changed.
  - SPACE: key_f rises before the gap threshold → MARK (same letter).
  - SPACE: half_units reaches 4 (2 units) → decode, then IDLE; pattern, sym_count and overflow clear.
- Decode table as (sym_count, pattern[n−1:0]):
  - A: (2, 01)
  - B: (4, 1000)
  - C: (4, 1010)
  - D: (3, 100)
  - E: (1, 0)
  - F: (4, 0010)
  - G: (3, 110)
  - H: (4, 0000)
- Decode result:
  - Table match without overflow → letter_valid.
  - Otherwise (no match, overflow, or sym_count = 0) → letter_err.
- A held mark saturates at 15 half-units and stays in MARK until release, then classifies as a dash.
- Reset values:
  - letter = 0, letter_valid = 0, letter_err = 0, pattern = 0, sym_count = 0.
  - FSM in IDLE; synchronizer and debounce flops at 0.

## Timing
- Input latency: 2 cycles from key_in to key_s; the debounce adds DEBOUNCE_CYCLES on both edges.
- letter_valid / letter_err rise exactly 2·UNIT_CYCLES cycles after the key_f falling edge of the last mark, and last one cycle.
- letter updates on the same edge that letter_valid rises.
- Letter gap and key_f rising edge in the same cycle: the decode is emitted, the FSM goes directly to MARK, and the new mark starts a fresh letter.
- Reset asserted mid-letter: no pulse is emitted, and capture restarts from IDLE.
- Classification thresholds are 1.5 units (dot/dash) and 2 units (letter gap). These fit the transmitter's 1-unit dot, 2-unit dash and 1-unit intra-letter gap.

## Configuration
- MORSE_RX_DEBOUNCE_EN defined:
  - key_f changes only after key_s has held its new value for DEBOUNCE_CYCLES consecutive cycles.
  - Shorter bounces are invisible to the FSM.
- MORSE_RX_DEBOUNCE_EN undefined:
  - key_f = key_s.
  - DEBOUNCE_CYCLES is ignored.
  - No debounce counter is synthesized.

## Structure
- Package morse_pkg:
  - FSM state enum.
  - Letter codes A..H = 0..7.
  - DOT_DASH_HALF = 3, LETTER_GAP_HALF = 4, MAX_SYMBOLS = 4.
  - Decode table constants.
  - The transmitter reuses the letter codes from this package.
- Sub-module morse_key_conditioner:
  - Contains the synchronizer and the macro-gated debounce.
  - Outputs key_f.

## Test plan
All scenarios use UNIT_CYCLES = 10 (half-unit = 5 cycles) with debounce off, except scenario 6.
1. Hold reset_n low for 3 cycles, then release → all outputs 0 and no pulses for 100 idle cycles.
2. Key A: mark 10, space 10, mark 20, then idle → a single letter_valid with letter = 0 and pattern = 01, 20 cycles (+2 sync) after the release.
3. Key H (four 10-cycle marks, 10-cycle gaps), then key G (20, 20, 10) with a 40-cycle gap between letters → letter_valid with letter = 7, then letter_valid with letter = 6.
4. Five 10-cycle dots → letter_err pulse, no letter_valid, letter keeps its previous value.
5. Reset scenario: a 3-cycle glitch mark, then E (mark 10); separately, reset asserted after two symbols of B.
   - The glitch mark leaves sym_count at 0, and E decodes to letter = 4.
   - The mid-letter reset clears sym_count to 0, and no pulse follows the release.
6. Debounce build: MORSE_RX_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 3, with 1-cycle bounces around a 10-cycle mark → exactly one dot is captured, and E decodes to letter = 4.
